pixel_fb_writer: RTL and testbench

Sink for the rasterizer's pixel stream. It accepts (pixel_x, pixel_y, colour) beats over a valid/ready handshake and turns each one into a write on a double-buffered framebuffer port. When the producer signals frame end, it drains its pipeline and swaps the front and back buffers. It sits between the rasterizer control output and the framebuffer BRAM, whose other port is read by the display scan-out.

---
 rtl/pixel_fb_writer_pkg.sv | 32 +++
 rtl/pixel_fb_writer_if.sv | 29 ++
 rtl/pixel_fb_writer_fb_addr_calc.sv | 38 +++
 rtl/pixel_fb_writer.sv | 107 ++++++++++
 tb/tb_pixel_fb_writer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_fb_writer_pkg.sv
// Shared constants, state encoding and the constant-multiply helper for the
// pixel framebuffer writer and its address generator.
package pixel_fb_writer_pkg;

  localparam int H_RES_DEF = 800;
  localparam int V_RES_DEF = 600;
  localparam int COORD_W   = 11;
  localparam int DATA_W    = 8;
  localparam int BUF_AW    = 19;

  localparam logic [DATA_W-1:0] TRANSPARENT = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  // y * k as a sum of shifted copies of y; k is a constant, so this folds
  // into a short adder chain (800 -> (y<<9)+(y<<8)+(y<<5)).
  function automatic logic [BUF_AW-1:0] mul_const(input logic [COORD_W-1:0] y,
                                                  input int k);
    logic [BUF_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (BUF_AW'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_fb_writer_if.sv
// Pixel stream input plus framebuffer write port, bundled as one bus.
// Handshakes: a beat moves when in_valid && in_ready; a write completes when
// fb_we && fb_ready. A producer never waits for ready before raising valid/we,
// and keeps its payload stable until the transfer completes.
interface pixel_fb_writer_if;
  import pixel_fb_writer_pkg::*;

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               frame_end;
  logic [BUF_AW:0]    fb_addr;
  logic [DATA_W-1:0]  fb_din;
  logic               fb_we;
  logic               fb_ready;

  modport master (
    output in_data, in_valid, pixel_x, pixel_y, frame_end, fb_ready,
    input  in_ready, fb_addr, fb_din, fb_we
  );

  modport slave (
    input  in_data, in_valid, pixel_x, pixel_y, frame_end, fb_ready,
    output in_ready, fb_addr, fb_din, fb_we
  );

endinterface

// File: rtl/pixel_fb_writer_fb_addr_calc.sv
// Registered coordinate stage: captures x and y*H_RES on enable and presents
// the buffer offset row+x together with an out-of-range flag.
module fb_addr_calc
  import pixel_fb_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [BUF_AW-1:0]  offset,
  output logic               oor
);

  logic [BUF_AW-1:0]  row_q;
  logic [COORD_W-1:0] x_q;
  logic               oor_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      row_q <= '0;
      x_q   <= '0;
      oor_q <= 1'b0;
    end else if (en) begin
      row_q <= mul_const(y, H_RES);
      x_q   <= x;
      oor_q <= (int'(x) >= H_RES) || (int'(y) >= V_RES);
    end
  end

  // Truncation to BUF_AW bits is harmless: in-range offsets always fit.
  assign offset = row_q + BUF_AW'(x_q);
  assign oor    = oor_q;

endmodule

// File: rtl/pixel_fb_writer.sv
// Two-stage pixel sink writing into the back half of a double-buffered
// framebuffer; drains and swaps buffers on each frame_end rising edge.
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                clk,
  input  logic                aresetn,
  pixel_fb_writer_if.slave    bus,
  output logic                front_sel,
  output logic                swap_pulse,
  output logic [19:0]         pix_written,
  output logic [15:0]         pix_dropped,
  output state_t              state
);

  state_t             next_state;
  logic               frame_end_q;
  logic               s1_valid, s2_valid, s2_oor;
  logic [DATA_W-1:0]  s1_data;
  logic [BUF_AW-1:0]  s1_offset;
  logic               s1_oor;
  logic               s2_fire, s2_free, s1_adv, accept, fe_rise, pipe_empty, wr_done;

  // S2 retires immediately when it holds no write; otherwise it waits for the grant.
  assign s2_fire    = s2_valid && (!bus.fb_we || bus.fb_ready);
  assign s2_free    = !s2_valid || s2_fire;
  assign s1_adv     = s1_valid && s2_free;
  assign bus.in_ready = (state == RUN) && (!s1_valid || s2_free);
  assign accept     = bus.in_valid && bus.in_ready;
  assign fe_rise    = bus.frame_end && !frame_end_q;
  assign pipe_empty = !s1_valid && !s2_valid;
  assign wr_done    = bus.fb_we && bus.fb_ready;
  assign swap_pulse = (state == SWAP);

  fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_addr (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (accept),
    .x       (bus.pixel_x),
    .y       (bus.pixel_y),
    .offset  (s1_offset),
    .oor     (s1_oor)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = RUN;
      RUN:     if (fe_rise) next_state = DRAIN;
      // An edge with nothing written (power-up, empty frame) does not swap.
      DRAIN:   if (pipe_empty) next_state = (pix_written != '0) ? SWAP : RUN;
      SWAP:    next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      frame_end_q <= 1'b1;
      front_sel   <= 1'b0;
      pix_written <= '0;
      pix_dropped <= '0;
    end else begin
      state       <= next_state;
      frame_end_q <= bus.frame_end;
      if (state == SWAP) front_sel <= ~front_sel;
      if (state == SWAP)   pix_written <= '0;
      else if (wr_done)    pix_written <= pix_written + 20'd1;
      if (s2_fire && s2_oor && pix_dropped != 16'hFFFF)
        pix_dropped <= pix_dropped + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s2_valid    <= 1'b0;
      s2_oor      <= 1'b0;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_din  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= bus.in_data;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid    <= 1'b1;
        s2_oor      <= s1_oor;
        bus.fb_addr <= {~front_sel, s1_offset};
        bus.fb_din  <= s1_data;
        bus.fb_we   <= !s1_oor && (s1_data != TRANSPARENT);
      end else if (s2_fire) begin
        s2_valid  <= 1'b0;
        bus.fb_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: reset, latency, filtering, backpressure,
// buffer swap, spurious frame edge and mid-frame reset.
module tb_pixel_fb_writer;
  import pixel_fb_writer_pkg::*;

  localparam int W = BUF_AW + 1 + DATA_W;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        front_sel, swap_pulse;
  logic [19:0] pix_written;
  logic [15:0] pix_dropped;
  state_t      state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pixel_fb_writer_if bus();

  pixel_fb_writer dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .bus         (bus),
    .front_sel   (front_sel),
    .swap_pulse  (swap_pulse),
    .pix_written (pix_written),
    .pix_dropped (pix_dropped),
    .state       (state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic exp_back = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int d, input logic fe);
    logic ok;
    ok = 1'b0;
    bus.pixel_x  = COORD_W'(x);
    bus.pixel_y  = COORD_W'(y);
    bus.in_data  = DATA_W'(d);
    bus.in_valid = 1'b1;
    if (fe) bus.frame_end = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_handshake", ok, 1);
    if (ok && x < H_RES_DEF && y < V_RES_DEF && d != 0)
      exp_q.push_back({exp_back, BUF_AW'(y * H_RES_DEF + x), DATA_W'(d)});
  endtask

  task automatic wait_ready(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    check(tag, ok, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic              stall_q = 1'b0;
  logic [BUF_AW:0]   stall_addr;
  logic [DATA_W-1:0] stall_din;

  always @(negedge clk) begin
    if (!aresetn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_addr", bus.fb_addr, stall_addr);
        check("stall_din", bus.fb_din, stall_din);
        check("stall_we", bus.fb_we, 1);
      end
      if (bus.fb_we && bus.fb_ready) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          check("write_data", {bus.fb_addr, bus.fb_din}, exp_q.pop_front());
      end
      stall_q    = bus.fb_we && !bus.fb_ready;
      stall_addr = bus.fb_addr;
      stall_din  = bus.fb_din;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [BUF_AW:0] addr;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.pixel_x   = '0;
    bus.pixel_y   = '0;
    bus.frame_end = 1'b0;
    bus.fb_ready  = 1'b1;

    // reset state
    wait_cycles(3);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_fb_addr", bus.fb_addr, 0);
    check("rst_fb_din", bus.fb_din, 0);
    check("rst_front_sel", front_sel, 0);
    check("rst_swap_pulse", swap_pulse, 0);
    check("rst_pix_written", pix_written, 0);
    check("rst_pix_dropped", pix_dropped, 0);
    check("rst_state", state, IDLE);
    aresetn = 1'b1;
    wait_ready("ready_after_reset");

    // spurious frame_end edge with nothing written
    bus.frame_end = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) check("spur_drain", state, DRAIN);
      cnt += int'(swap_pulse);
    end
    check("spur_swaps", cnt, 0);
    check("spur_front_sel", front_sel, 0);
    check("spur_state", state, RUN);
    check("spur_in_ready", bus.in_ready, 1);
    bus.frame_end = 1'b0;
    wait_cycles(1);

    // single write and its latency
    send(3, 2, 8'h05, 1'b0);
    @(negedge clk);
    check("lat_we_n1", bus.fb_we, 0);
    @(negedge clk);
    addr = bus.fb_addr;
    check("lat_we_n2", bus.fb_we, 1);
    check("lat_offset", addr[BUF_AW-1:0], 1603);
    check("lat_back_sel", addr[BUF_AW], 1);
    check("lat_din", bus.fb_din, 8'h05);
    wait_cycles(3);
    check("single_written", pix_written, 1);

    // filtering
    send(10, 10, 8'h00, 1'b0);
    wait_cycles(4);
    check("transparent_written", pix_written, 1);
    send(800, 0, 8'h07, 1'b0);
    wait_cycles(4);
    check("oor_dropped", pix_dropped, 1);
    check("oor_written", pix_written, 1);
    send(799, 599, 8'h01, 1'b0);
    wait_cycles(4);
    check("corner_written", pix_written, 2);
    check("corner_dropped", pix_dropped, 1);

    // backpressure over a 4-beat stream
    fork
      begin
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i >= 2) check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.fb_ready = 1'b1;
      end
      begin
        send(1, 1, 8'h11, 1'b0);
        send(2, 1, 8'h22, 1'b0);
        send(3, 1, 8'h33, 1'b0);
        send(4, 1, 8'h44, 1'b0);
      end
    join
    wait_cycles(6);
    check("bp_written", pix_written, 6);
    check("bp_queue_empty", exp_q.size(), 0);

    // frame swap; last beat shares its cycle with the frame_end edge
    send(5, 5, 8'h0a, 1'b0);
    send(6, 5, 8'h0b, 1'b0);
    send(7, 5, 8'h0c, 1'b1);
    exp_back = 1'b0;
    @(negedge clk);
    check("drain_in_ready", bus.in_ready, 0);
    check("drain_state", state, DRAIN);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(swap_pulse);
    end
    check("swap_pulses", cnt, 1);
    check("swap_front_sel", front_sel, 1);
    check("swap_written", pix_written, 0);
    check("swap_state", state, RUN);
    check("swap_queue_empty", exp_q.size(), 0);
    bus.frame_end = 1'b0;
    wait_cycles(1);
    send(0, 0, 8'h02, 1'b0);
    wait_cycles(4);
    check("new_frame_written", pix_written, 1);

    // reset while S2 is stalled on a write
    bus.fb_ready = 1'b0;
    send(5, 5, 8'h09, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_we", bus.fb_we, 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_we", bus.fb_we, 0);
    check("mid_rst_written", pix_written, 0);
    check("mid_rst_dropped", pix_dropped, 0);
    check("mid_rst_front_sel", front_sel, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    bus.fb_ready = 1'b1;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    exp_back = 1'b1;
    wait_ready("ready_after_mid_reset");
    send(1, 0, 8'h03, 1'b0);
    wait_cycles(4);
    check("post_reset_written", pix_written, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
